// File: rtl/matriz_seq_pkg.sv
// matriz_seq_pkg: matrix geometry, opcodes and sequencer state type shared by the matriz_seq slice
package matriz_seq_pkg;
  localparam int N = 5;
  localparam int ELEM_W = 8;
  localparam int ROW_W = N * ELEM_W;
  localparam int MAT_W = N * ROW_W;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SMUL = 3'd2;
  localparam logic [2:0] OP_TRANS = 3'd3;
  localparam logic [2:0] OP_OPP = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_DONE} state_t;
  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_OPP;
  endfunction
  // Operations that only consume matrix A.
  function automatic logic op_unary(input logic [2:0] op);
    return op inside {OP_SMUL, OP_TRANS, OP_OPP};
  endfunction
endpackage

// File: rtl/matriz_seq_if.sv
// matriz_seq_if: command handshake, matrix memory port and ALU operand/result bundle
// slave = sequencer side, master = front-end / memory / ALU side.
interface matriz_seq_if #(parameter int ADDR_W = 8);
  import matriz_seq_pkg::*;
  logic start;
  logic [2:0] opcode;
  logic [ELEM_W-1:0] scalar;
  logic [ADDR_W-1:0] base_a, base_b, base_r;
  logic busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd_en, mem_wr_en;
  logic [ROW_W-1:0] mem_wdata, mem_rdata;
  logic [MAT_W-1:0] alu_a, alu_b, alu_result;
  logic [ELEM_W-1:0] alu_scalar;
  logic [2:0] alu_op;
  modport slave (
    input start, opcode, scalar, base_a, base_b, base_r, mem_rdata, alu_result,
    output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, alu_a, alu_b, alu_scalar, alu_op
  );
  modport master (
    output start, opcode, scalar, base_a, base_b, base_r, mem_rdata, alu_result,
    input busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, alu_a, alu_b, alu_scalar, alu_op
  );
endinterface

// File: rtl/matriz_seq_row_ctr.sv
// matriz_seq_row_ctr: 0..5 row counter shared by the load and store phases
// Ports: clk, rst_n, clr (to 0, wins), en (increment), cnt, lt5 (cnt<5), ge1 (cnt>=1).
module matriz_seq_row_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] cnt,
  output logic       lt5,
  output logic       ge1
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? 3'd0 : en ? cnt + 3'd1 : cnt;
  assign lt5 = cnt < 3'd5;
  assign ge1 = cnt != 3'd0;
endmodule

// File: rtl/matriz_seq.sv
// matriz_seq: loads A/B row by row, runs the 5x5 matrix ALU, stores the result rows
// Ports: clk, rst_n (async, active low), bus (matriz_seq_if.slave: command handshake,
// matrix memory port, ALU operands/result). Option: MATRIZ_SEQ_SKIP_B_EN skips LOAD_B
// for the single-operand opcodes (scalar mul, transpose, opposite).
module matriz_seq
  import matriz_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  matriz_seq_if.slave bus
);
  state_t state;
  logic [2:0] cnt, row_prev, row_next;
  logic lt5, ge1, clr, en, load, skip_b;
  logic [ADDR_W-1:0] base_b_q, base_r_q, addr_q;
  logic busy_q, done_q, err_q, rd_q, wr_q;
  logic [ROW_W-1:0] wdata_q;
  logic [MAT_W-1:0] a_q, b_q, res_q;
  logic [ELEM_W-1:0] scalar_q;
  logic [2:0] op_q;
  logic [15:0] lat_q;
  // Counter is cleared on the last cycle of each phase so every phase starts at row 0.
  assign load = state == S_LOAD_A || state == S_LOAD_B;
  assign en = load || state == S_STORE;
  assign clr = (load && !lt5) || (state == S_STORE && cnt == 3'd4);
  assign row_prev = cnt - 3'd1;
  assign row_next = cnt + 3'd1;
`ifdef MATRIZ_SEQ_SKIP_B_EN
  assign skip_b = op_unary(op_q);
`else
  assign skip_b = 1'b0;
`endif
  matriz_seq_row_ctr u_row_ctr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .cnt(cnt), .lt5(lt5), .ge1(ge1)
  );
  // Memory-port outputs are registered, so each branch sets up what the next cycle drives:
  // a read issued with counter c returns data when the counter is c+1, landing in row c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      scalar_q <= '0;
      op_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      lat_q <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.start) begin
            op_q <= bus.opcode;
            scalar_q <= bus.scalar;
            base_b_q <= bus.base_b;
            base_r_q <= bus.base_r;
            busy_q <= 1'b1;
            if (op_valid(bus.opcode)) begin
              state <= S_LOAD_A;
              rd_q <= 1'b1;
              addr_q <= bus.base_a;
            end else begin
              state <= S_DONE;
              done_q <= 1'b1;
              err_q <= 1'b1;
            end
          end
        S_LOAD_A, S_LOAD_B: begin
          if (ge1 && state == S_LOAD_A) a_q[int'(row_prev) * ROW_W +: ROW_W] <= bus.mem_rdata;
          if (ge1 && state == S_LOAD_B) b_q[int'(row_prev) * ROW_W +: ROW_W] <= bus.mem_rdata;
          rd_q <= cnt < 3'd4;
          addr_q <= cnt < 3'd4 ? addr_q + ADDR_W'(1) : addr_q;
          if (!lt5) begin
            if (state == S_LOAD_A && !skip_b) begin
              state <= S_LOAD_B;
              rd_q <= 1'b1;
              addr_q <= base_b_q;
            end else state <= S_EXEC;
          end
        end
        S_EXEC:
          if (lat_q == 16'(ALU_LAT - 1)) begin
            lat_q <= '0;
            res_q <= bus.alu_result;
            wdata_q <= bus.alu_result[ROW_W-1:0];
            wr_q <= 1'b1;
            addr_q <= base_r_q;
            state <= S_STORE;
          end else lat_q <= lat_q + 16'd1;
        S_STORE:
          if (cnt == 3'd4) begin
            wr_q <= 1'b0;
            done_q <= 1'b1;
            state <= S_DONE;
          end else begin
            wdata_q <= res_q[int'(row_next) * ROW_W +: ROW_W];
            addr_q <= addr_q + ADDR_W'(1);
          end
        S_DONE: begin
          done_q <= 1'b0;
          err_q <= 1'b0;
          busy_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.alu_scalar = scalar_q;
  assign bus.alu_op = op_q;
endmodule

// File: tb/tb_matriz_seq.sv
// tb_matriz_seq: directed and random commands against a memory/ALU model and a matrix-level reference
module tb_matriz_seq;
  import matriz_seq_pkg::*;
  localparam int W = MAT_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  matriz_seq_if #(.ADDR_W(8)) bus ();
  matriz_seq #(.ADDR_W(8), .ALU_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [ROW_W-1:0] mem [256];
  logic [7:0] rd_log[$];
  logic [7:0] wr_log[$];
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  bit both_seen = 1'b0;
  logic [MAT_W-1:0] exp_a = '0;
  logic [MAT_W-1:0] exp_b = '0;

  function automatic logic [7:0] el(input logic [MAT_W-1:0] m, input int r, input int i);
    return m[(r * N + i) * ELEM_W +: ELEM_W];
  endfunction

  // Matrix semantics of the five operations, element by element, 8-bit wrap.
  function automatic logic [MAT_W-1:0] alu_fn(input logic [2:0] op, input logic [7:0] s,
                                              input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] c;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int i = 0; i < N; i++) begin
        logic [7:0] z;
        case (op)
          OP_ADD: z = el(a, r, i) + el(b, r, i);
          OP_SUB: z = el(a, r, i) - el(b, r, i);
          OP_SMUL: z = el(a, r, i) * s;
          OP_TRANS: z = el(a, i, r);
          default: z = 8'd0 - el(a, r, i);
        endcase
        c[(r * N + i) * ELEM_W +: ELEM_W] = z;
      end
    return c;
  endfunction

  function automatic logic [MAT_W-1:0] rows(input logic [7:0] base);
    logic [MAT_W-1:0] v;
    for (int r = 0; r < N; r++) v[r * ROW_W +: ROW_W] = mem[8'(int'(base) + r)];
    return v;
  endfunction

  function automatic logic [87:0] qpack(input logic [7:0] q[$]);
    logic [87:0] v;
    v = '0;
    v[87:80] = 8'(q.size());
    foreach (q[k]) if (k < 10) v[k * 8 +: 8] = q[k];
    return v;
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_op, bus.alu_scalar, bus.alu_a, bus.alu_b);

  // Row-wide memory: read data one cycle after the read strobe; logs every access.
  always @(posedge clk) begin
    if (bus.mem_rd_en && bus.mem_wr_en) both_seen = 1'b1;
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_log.push_back(bus.mem_addr);
    end
    if (bus.mem_rd_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      rd_log.push_back(bus.mem_addr);
    end
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, W'({bus.busy, bus.done, bus.err, bus.mem_rd_en, bus.mem_wr_en}), W'(0));
    chk({tag, "_addr"}, W'(bus.mem_addr), W'(0));
    chk({tag, "_wdata"}, W'(bus.mem_wdata), W'(0));
    chk({tag, "_alu_a"}, bus.alu_a, W'(0));
    chk({tag, "_alu_b"}, bus.alu_b, W'(0));
    chk({tag, "_cmd"}, W'({bus.alu_scalar, bus.alu_op}), W'(0));
  endtask

  // Issues one command from IDLE (called #1 after a rising edge) and checks everything it did.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] s, input logic [7:0] ba,
                         input logic [7:0] bb, input logic [7:0] br, input bit hold);
    logic [MAT_W-1:0] a, b, pre_r, want;
    logic [7:0] exp_rd[$];
    logic [7:0] exp_wr[$];
    int lat, want_lat, d0;
    bit bad, skip;
    bad = op > 3'd4;
    skip = 1'b0;
`ifdef MATRIZ_SEQ_SKIP_B_EN
    skip = op inside {3'd2, 3'd3, 3'd4};
`endif
    a = rows(ba);
    b = rows(bb);
    pre_r = rows(br);
    want = bad ? pre_r : alu_fn(op, s, a, b);
    want_lat = bad ? 1 : skip ? 13 : 19;
    for (int r = 0; r < N; r++) if (!bad) exp_rd.push_back(8'(int'(ba) + r));
    for (int r = 0; r < N; r++) if (!bad && !skip) exp_rd.push_back(8'(int'(bb) + r));
    for (int r = 0; r < N; r++) if (!bad) exp_wr.push_back(8'(int'(br) + r));
    rd_log.delete();
    wr_log.delete();
    both_seen = 1'b0;
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.opcode = op;
    bus.scalar = s;
    bus.base_a = ba;
    bus.base_b = bb;
    bus.base_r = br;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start = 1'b0;
      bus.opcode = 3'($urandom);
      bus.scalar = 8'($urandom);
      bus.base_a = 8'($urandom);
      bus.base_b = 8'($urandom);
      bus.base_r = 8'($urandom);
    end
    lat = 1;
    chk("busy_after_start", W'(bus.busy), W'(1));
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", W'(lat), W'(want_lat));
    chk("err", W'(bus.err), W'(bad));
    chk("alu_cmd", W'({bus.alu_scalar, bus.alu_op}), W'({s, op}));
    if (!bad) exp_a = a;
    if (!bad && !skip) exp_b = b;
    @(posedge clk);
    #1;
    chk("idle_flags", W'({bus.busy, bus.done, bus.err}), W'(0));
    chk("alu_a_hold", bus.alu_a, exp_a);
    chk("alu_b_hold", bus.alu_b, exp_b);
    chk("read_addrs", W'(qpack(rd_log)), W'(qpack(exp_rd)));
    chk("write_addrs", W'(qpack(wr_log)), W'(qpack(exp_wr)));
    chk("result_rows", rows(br), want);
    chk("done_pulses", W'(done_cnt - d0), W'(1));
    chk("rd_wr_overlap", W'(both_seen), W'(0));
  endtask

  initial begin
    logic [MAT_W-1:0] pre, want;
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.scalar = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.base_r = '0;
    for (int k = 0; k < 256; k++) mem[k] = 40'({$urandom(), $urandom()});
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Add: all-ones plus all-twos.
    for (int r = 0; r < N; r++) begin
      mem[r] = {5{8'h01}};
      mem[8'h10 + r] = {5{8'h02}};
    end
    run_cmd(OP_ADD, 8'd0, 8'h00, 8'h10, 8'h20, 1'b0);
    chk("add_row0", W'(mem[8'h20]), W'(40'h0303030303));
    chk("add_row4", W'(mem[8'h24]), W'(40'h0303030303));
    // Scalar multiply by 3 with element i = i.
    for (int r = 0; r < N; r++) mem[r] = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    run_cmd(OP_SMUL, 8'd3, 8'h00, 8'h10, 8'h20, 1'b0);
    chk("smul_row2", W'(mem[8'h22]), W'({8'd12, 8'd9, 8'd6, 8'd3, 8'd0}));
    // Invalid opcode: immediate done/err, no memory traffic.
    run_cmd(3'd6, 8'd7, 8'h30, 8'h40, 8'h50, 1'b0);
    // Base address wrapping past 0xFF.
    run_cmd(OP_OPP, 8'd0, 8'hFE, 8'h10, 8'h80, 1'b0);
    run_cmd(OP_SUB, 8'd0, 8'hFC, 8'hFD, 8'hFB, 1'b0);
    // start held high for the whole command.
    run_cmd(OP_SUB, 8'd0, 8'h60, 8'h70, 8'h90, 1'b1);
    run_cmd(OP_TRANS, 8'd0, 8'hA0, 8'hB0, 8'hC0, 1'b1);
    // Random commands, including invalid opcodes and overlapping regions.
    for (int t = 0; t < 10; t++)
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    // Reset in the middle of STORE after two rows have been written.
    pre = rows(8'h60);
    want = alu_fn(OP_ADD, 8'd0, rows(8'h40), rows(8'h50));
    rd_log.delete();
    wr_log.delete();
    bus.start = 1'b1;
    bus.opcode = OP_ADD;
    bus.base_a = 8'h40;
    bus.base_b = 8'h50;
    bus.base_r = 8'h60;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("pre_reset_writes", W'(wr_log.size()), W'(2));
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_writes", W'(wr_log.size()), W'(2));
    chk("post_reset_rows", rows(8'h60), {pre[MAT_W-1:2*ROW_W], want[2*ROW_W-1:0]});
    chk("post_reset_busy", W'(bus.busy), W'(0));
    exp_a = '0;
    exp_b = '0;
    run_cmd(OP_ADD, 8'd0, 8'h40, 8'h50, 8'h60, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
